// File: rtl/regfile_pkg.sv
// Shared register-file geometry and types, used by operand_fetch and register_file.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [NUM_REGS-1:0] regmask_t;

    localparam addr_t ZERO_REG = '0;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode/execute handshakes, writeback bus and regfile ports of the operand-fetch stage.
interface operand_fetch_if;
    import regfile_pkg::*;

    logic     in_valid;
    logic     in_ready;
    addr_t    in_rs1;
    addr_t    in_rs2;
    addr_t    in_rd;
    logic     in_rd_en;

    logic     out_valid;
    logic     out_ready;
    data_t    out_rs1_data;
    data_t    out_rs2_data;
    addr_t    out_rd;
    logic     out_rd_en;

    logic     wb_en;
    addr_t    wb_reg;
    data_t    wb_data;

    addr_t    reg_read1;
    addr_t    reg_read2;
    data_t    data_read1;
    data_t    data_read2;
    addr_t    reg_write;
    data_t    data_write;
    logic     write_enable;

    regmask_t pending;

    // master: the operand-fetch stage itself; slave: decode, execute, writeback and regfile.
    modport master (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_en, out_ready,
        input  wb_en, wb_reg, wb_data, data_read1, data_read2,
        output in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en,
        output reg_read1, reg_read2, reg_write, data_write, write_enable, pending
    );

    modport slave (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_en, out_ready,
        output wb_en, wb_reg, wb_data, data_read1, data_read2,
        input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en,
        input  reg_read1, reg_read2, reg_write, data_write, write_enable, pending
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write bitmap with hazard query; a same-edge writeback hides the hazard it resolves.
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  addr_t           set_reg,
    input  logic            clr_en,
    input  addr_t           clr_reg,
    input  addr_t [2:0]     query,
    output logic  [2:0]     hazard,
    output regmask_t        pending
);

    regmask_t pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_en && clr_reg != ZERO_REG) pending_d[clr_reg] = 1'b0;
        // Applied after the clear so a same-edge set wins.
        if (set_en && set_reg != ZERO_REG) pending_d[set_reg] = 1'b1;
    end

    always_comb begin
        hazard = '0;
        for (int i = 0; i < 3; i++) begin
            hazard[i] = (query[i] != ZERO_REG) && pending_q[query[i]] &&
                        !(clr_en && clr_reg == query[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign pending = pending_q;

endmodule

// File: rtl/register_file.sv
// Register file with registered reads (old value on same-edge write) and hardwired-zero x0.
module register_file
    import regfile_pkg::*;
(
    input  logic  clk,
    input  addr_t reg_read1,
    input  addr_t reg_read2,
    output data_t data_read1,
    output data_t data_read2,
    input  addr_t reg_write,
    input  data_t data_write,
    input  logic  write_enable
);

    data_t mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (write_enable && reg_write != ZERO_REG) mem[reg_write] <= data_write;
        data_read1 <= (reg_read1 == ZERO_REG) ? '0 : mem[reg_read1];
        data_read2 <= (reg_read2 == ZERO_REG) ? '0 : mem[reg_read2];
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: one-entry stage register over a 1-cycle regfile, writeback bypass
// at accept, and scoreboard-driven RAW/WAW stall.
module operand_fetch
    import regfile_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    operand_fetch_if.master bus
);

    logic        valid_q;
    addr_t       rs1_q, rs2_q, rd_q;
    logic        rd_en_q;
    logic        byp1_q, byp2_q;
    data_t       byp_data1_q, byp_data2_q;

    logic        accept;
    logic [2:0]  hazard;
    logic        byp1_hit, byp2_hit;

    reg_scoreboard u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (accept && bus.in_rd_en),
        .set_reg (bus.in_rd),
        .clr_en  (bus.wb_en),
        .clr_reg (bus.wb_reg),
        .query   ({bus.in_rd, bus.in_rs2, bus.in_rs1}),
        .hazard  (hazard),
        .pending (bus.pending)
    );

    assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard[0] && !hazard[1] &&
                          !(bus.in_rd_en && hazard[2]);
    assign accept       = bus.in_valid && bus.in_ready;

    // While stalled, keep addressing the held sources so the regfile output stays valid.
    assign bus.reg_read1 = bus.in_ready ? bus.in_rs1 : rs1_q;
    assign bus.reg_read2 = bus.in_ready ? bus.in_rs2 : rs2_q;

    assign byp1_hit = bus.wb_en && bus.wb_reg == bus.in_rs1 && bus.in_rs1 != ZERO_REG;
    assign byp2_hit = bus.wb_en && bus.wb_reg == bus.in_rs2 && bus.in_rs2 != ZERO_REG;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rd_en_q     <= 1'b0;
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
            byp_data1_q <= '0;
            byp_data2_q <= '0;
        end else if (accept) begin
            valid_q     <= 1'b1;
            rs1_q       <= bus.in_rs1;
            rs2_q       <= bus.in_rs2;
            rd_q        <= bus.in_rd;
            rd_en_q     <= bus.in_rd_en;
            byp1_q      <= byp1_hit;
            byp2_q      <= byp2_hit;
            byp_data1_q <= bus.wb_data;
            byp_data2_q <= bus.wb_data;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_rd_en    = rd_en_q;
    assign bus.out_rs1_data = (rs1_q == ZERO_REG) ? '0 : byp1_q ? byp_data1_q : bus.data_read1;
    assign bus.out_rs2_data = (rs2_q == ZERO_REG) ? '0 : byp2_q ? byp_data2_q : bus.data_read2;

    // Write port is a pure pass-through, live even during reset.
    assign bus.reg_write    = bus.wb_reg;
    assign bus.data_write   = bus.wb_data;
    assign bus.write_enable = bus.wb_en;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench: operand_fetch driving a register_file, hand-computed expected values.
module tb_operand_fetch;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    register_file u_rf (
        .clk          (clk),
        .reg_read1    (bus.reg_read1),
        .reg_read2    (bus.reg_read2),
        .data_read1   (bus.data_read1),
        .data_read2   (bus.data_read2),
        .reg_write    (bus.reg_write),
        .data_write   (bus.data_write),
        .write_enable (bus.write_enable)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input addr_t rs1, input addr_t rs2, input addr_t rd, input logic rd_en);
        bus.in_valid = 1'b1;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_rd    = rd;
        bus.in_rd_en = rd_en;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_rs1   = '0;
        bus.in_rs2   = '0;
        bus.in_rd    = '0;
        bus.in_rd_en = 1'b0;
    endtask

    task automatic wb(input logic en, input addr_t r, input data_t d);
        bus.wb_en   = en;
        bus.wb_reg  = r;
        bus.wb_data = d;
    endtask

    // Back-to-back vectors: {rs1, rs2, expected op1, expected op2}
    addr_t v_rs1 [4] = '{5'd5, 5'd3, 5'd6, 5'd0};
    addr_t v_rs2 [4] = '{5'd6, 5'd5, 5'd3, 5'd6};
    data_t v_op1 [4] = '{32'd50, 32'd7, 32'd60, 32'd0};
    data_t v_op2 [4] = '{32'd60, 32'd50, 32'd7, 32'd60};

    initial begin
        reset = 1'b1;
        bus.out_ready = 1'b1;
        idle();
        wb(1'b0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("reset_out_valid", bus.out_valid, 0);
        check_eq("reset_pending", bus.pending, 0);
        check_eq("reset_out_rd", bus.out_rd, 0);

        // 1: preload x5=50, x6=60, then read x5/x0
        wb(1'b1, 5'd5, 32'd50);
        tick();
        wb(1'b1, 5'd6, 32'd60);
        tick();
        wb(1'b0, '0, '0);
        issue(5'd5, 5'd0, 5'd0, 1'b0);
        #1;
        check_eq("t1_in_ready", bus.in_ready, 1);
        tick();
        idle();
        #1;
        check_eq("t1_out_valid", bus.out_valid, 1);
        check_eq("t1_rs1_data", bus.out_rs1_data, 50);
        check_eq("t1_rs2_data", bus.out_rs2_data, 0);
        tick();

        // 2: RAW stall on x3, released by same-edge writeback with bypass
        issue(5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        check_eq("t2_pending3", bus.pending, 32'h8);
        check_eq("t2_out_rd", bus.out_rd, 3);
        issue(5'd3, 5'd0, 5'd0, 1'b0);
        #1;
        check_eq("t2_stall_a", bus.in_ready, 0);
        tick();
        check_eq("t2_stall_b", bus.in_ready, 0);
        check_eq("t2_drained", bus.out_valid, 0);
        wb(1'b1, 5'd3, 32'd7);
        #1;
        check_eq("t2_ready_on_wb", bus.in_ready, 1);
        tick();
        wb(1'b0, '0, '0);
        idle();
        #1;
        check_eq("t2_out_valid", bus.out_valid, 1);
        check_eq("t2_bypass", bus.out_rs1_data, 7);
        check_eq("t2_pending_clr", bus.pending, 0);
        tick();

        // 3: hold for 3 cycles
        bus.out_ready = 1'b0;
        issue(5'd5, 5'd6, 5'd0, 1'b0);
        tick();
        issue(5'd3, 5'd5, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("t3_hold_valid%0d", i), bus.out_valid, 1);
            check_eq($sformatf("t3_hold_op1_%0d", i), bus.out_rs1_data, 50);
            check_eq($sformatf("t3_hold_op2_%0d", i), bus.out_rs2_data, 60);
            check_eq($sformatf("t3_hold_ready%0d", i), bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("t3_release_ready", bus.in_ready, 1);
        tick();
        idle();
        #1;
        check_eq("t3_next_op1", bus.out_rs1_data, 7);
        check_eq("t3_next_op2", bus.out_rs2_data, 50);
        tick();

        // 4: back-to-back independent issues
        for (int i = 0; i < 4; i++) begin
            issue(v_rs1[i], v_rs2[i], 5'd0, 1'b0);
            #1;
            check_eq($sformatf("t4_ready%0d", i), bus.in_ready, 1);
            tick();
            check_eq($sformatf("t4_valid%0d", i), bus.out_valid, 1);
            check_eq($sformatf("t4_op1_%0d", i), bus.out_rs1_data, v_op1[i]);
            check_eq($sformatf("t4_op2_%0d", i), bus.out_rs2_data, v_op2[i]);
        end
        idle();
        tick();

        // 5: same-edge set/clear on x4; rd=0 never sets
        issue(5'd0, 5'd0, 5'd4, 1'b1);
        tick();
        idle();
        check_eq("t5_pending4", bus.pending, 32'h10);
        tick();
        wb(1'b1, 5'd4, 32'd44);
        issue(5'd0, 5'd0, 5'd4, 1'b1);
        #1;
        check_eq("t5_waw_ready", bus.in_ready, 1);
        tick();
        wb(1'b0, '0, '0);
        idle();
        check_eq("t5_set_wins", bus.pending, 32'h10);
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        idle();
        check_eq("t5_rd0", bus.pending, 32'h10);
        wb(1'b1, 5'd4, 32'd45);
        tick();
        wb(1'b0, '0, '0);
        check_eq("t5_cleared", bus.pending, 0);

        // 6: reset mid-operation, writeback during reset
        bus.out_ready = 1'b0;
        issue(5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        idle();
        check_eq("t6_pre_valid", bus.out_valid, 1);
        check_eq("t6_pre_pending", bus.pending, 32'h8);
        reset = 1'b1;
        wb(1'b1, 5'd9, 32'd90);
        tick();
        reset = 1'b0;
        wb(1'b0, '0, '0);
        check_eq("t6_rst_valid", bus.out_valid, 0);
        check_eq("t6_rst_pending", bus.pending, 0);
        check_eq("t6_rst_rd_en", bus.out_rd_en, 0);
        bus.out_ready = 1'b1;
        issue(5'd9, 5'd0, 5'd0, 1'b0);
        tick();
        idle();
        check_eq("t6_x9", bus.out_rs1_data, 90);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
